// File: rtl/operand_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// operand_sweep_ctrl
//
// Sweeps two WIDTH-bit operands exhaustively through a unit under test. B is
// the inner loop and A the outer loop. One pair is presented per accepted
// cycle (valid && ready). A one-cycle done pulse marks the end of the sweep.
//
// Optional feature macro: SWEEP_RESULT_COUNT_EN
//   defined   : a RES_LAT-deep accept-tag pipeline samples resultA/resultB
//               and tallies the ones into onesA/onesB; a DRAIN phase waits
//               for the last result before done.
//   undefined : onesA/onesB read 0, results are ignored, and the sweep goes
//               straight from RUN to DONE after the last accept.
//
// Ports
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   start            begin a sweep (sampled only in IDLE)
//   abort            terminate in any state; wins over start and completion
//   ready            UUT accepts the presented pair when valid is high
//   resultA/resultB  UUT results, valid RES_LAT cycles after the accept
//   inputA/inputB    operands (A outer loop, B inner loop)
//   valid            pair on inputA/inputB is presented
//   busy             high in RUN or DRAIN
//   done             one-cycle completion pulse
//   onesA/onesB      saturating counts of resultA==1 / resultB==1 samples
// -----------------------------------------------------------------------------
module operand_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int RES_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             ready,
    input  logic             resultA,
    input  logic             resultB,
    output logic [WIDTH-1:0] inputA,
    output logic [WIDTH-1:0] inputB,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [2*WIDTH:0] onesA,
    output logic [2*WIDTH:0] onesB
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = 2 * WIDTH + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef SWEEP_RESULT_COUNT_EN
    localparam logic [1:0] S_AFTER_RUN = S_DRAIN;
`else
    localparam logic [1:0] S_AFTER_RUN = S_DONE;
`endif

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pair_q, pair_d;      // {A, B}: a single counter gives the nested-loop order
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          accept;
    logic          last_pair;
    logic          drain_empty;

    assign accept    = (state_q == S_RUN) && valid_q && ready;
    assign last_pair = &pair_q;

`ifdef SWEEP_RESULT_COUNT_EN
    logic [RES_LAT-1:0] tag_q, tag_d;
    logic [CW-1:0]      ones_a_q, ones_a_d;
    logic [CW-1:0]      ones_b_q, ones_b_d;
    logic               tag_out;

    // A tag leaving the pipeline marks the cycle its result is on resultA/B.
    assign tag_out = tag_q[RES_LAT-1];

    always_comb begin
        tag_d    = tag_q << 1;
        tag_d[0] = accept;
        ones_a_d = ones_a_q;
        ones_b_d = ones_b_q;
        if (tag_out && resultA && (ones_a_q != '1)) ones_a_d = ones_a_q + CW'(1);
        if (tag_out && resultB && (ones_b_q != '1)) ones_b_d = ones_b_q + CW'(1);
        if (abort) begin
            tag_d    = '0;
            ones_a_d = ones_a_q;
            ones_b_d = ones_b_q;
        end else if ((state_q == S_IDLE) && start) begin
            ones_a_d = '0;
            ones_b_d = '0;
        end
    end

    // In DRAIN no new tags enter, so an empty next pipeline means the last
    // result is being sampled at this edge.
    assign drain_empty = (tag_d == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the tag pipeline is reset, not left to flush: a stale tag
            // would be counted as a result in the next sweep.
            tag_q    <= '0;
            ones_a_q <= '0;
            ones_b_q <= '0;
        end else begin
            tag_q    <= tag_d;
            ones_a_q <= ones_a_d;
            ones_b_q <= ones_b_d;
        end
    end

    assign onesA = ones_a_q;
    assign onesB = ones_b_q;
`else
    logic unused_results;

    assign unused_results = resultA ^ resultB ^ (RES_LAT > 0);
    assign drain_empty    = 1'b1;
    assign onesA          = '0;
    assign onesB          = '0;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        state_d = state_q;
        pair_d  = pair_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pair_d  = '0;
                    valid_d = 1'b1;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (last_pair) begin
                        // Operands keep (max, max) rather than wrapping.
                        state_d = S_AFTER_RUN;
                        valid_d = 1'b0;
                    end else begin
                        pair_d = pair_q + PW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_empty) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            pair_d  = pair_q;
            valid_d = 1'b0;
        end
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pair_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values regardless of statement order.
            state_q <= state_d;
            pair_q  <= pair_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign inputA = pair_q[PW-1:WIDTH];
    assign inputB = pair_q[WIDTH-1:0];
    assign valid  = valid_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/operand_sweep_ctrl.md
# operand_sweep_ctrl

Sequencer that sweeps two WIDTH-bit operands exhaustively through a unit under test in nested-loop order: B varies fastest and A increments each time B wraps. It presents one pair per accepted cycle under a valid/ready handshake and reports completion with a one-cycle done pulse. Optionally, it tallies the UUT's two 1-bit results over the sweep. It sits between bench/top-level control and the UUT operand inputs, replacing free-running operand counters.

## Interface
- WIDTH, 4, operand width; sweep length is 2^(2*WIDTH) pairs
- RES_LAT, 1, cycles from operand accept to the matching result being valid on resultA/resultB; legal range 1..8

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  terminate sweep; honoured in any state
- ready  in  1  UUT accepts current pair when valid && ready
- resultA  in  1  UUT result A, valid RES_LAT cycles after accept
- resultB  in  1  UUT result B, same timing
- inputA  out  WIDTH  operand A (outer loop)
- inputB  out  WIDTH  operand B (inner loop)
- valid  out  1  pair on inputA/inputB is presented
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse at sweep completion
- onesA  out  2*WIDTH+1  count of resultA==1 samples (see Configuration)
- onesB  out  2*WIDTH+1  count of resultB==1 samples

## Operation
- States: IDLE, RUN, DRAIN, DONE; all outputs registered.
- Reset (rst_n==0 at an edge): state IDLE; inputA=0, inputB=0, valid=0, busy=0, done=0, onesA=0, onesB=0; accept-tag pipeline cleared.
- IDLE: valid=0. If start && !abort, go to RUN with inputA=0, inputB=0, valid=1, and clear onesA/onesB.
- RUN: on accept (valid && ready), inputB increments. If inputB was all-ones, it wraps to 0 and inputA increments. If the accepted pair was (all-ones, all-ones), go to DRAIN with valid=0; operands hold their last values. Without accept, all outputs hold (no operand change while valid && !ready).
- DRAIN: wait until the result of the last accept has been sampled, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. Counts hold until the next start.
- Result sampling: each accept pushes a tag into a RES_LAT-deep shift pipeline. When a tag emerges, resultA/resultB are sampled, and onesA/onesB increment when the corresponding bit is 1. Counts saturate at their maximum (never reached for a full sweep: max 2^(2*WIDTH)).
- abort: from any state, the next state is IDLE, valid=0, busy=0, done=0, and the tag pipeline is cleared. Operands and counts freeze. Abort has priority over start and over the RUN→DRAIN transition.
- start while not IDLE: ignored.

## Timing
- start sampled high at edge k: valid=1 with (0,0) after edge k.
- With ready held 1: pair n (n=0..2^(2W)-1) is accepted at edge k+1+n. The last accept is at k+2^(2W), and the state becomes DRAIN.
- The result of an accept at edge e is sampled at edge e+RES_LAT.
- State becomes DONE at edge k+2^(2W)+RES_LAT; done is high until the next edge.
- For WIDTH=4, RES_LAT=1: last accept at k+256, done high after k+257, IDLE after k+258.
- ready low for m cycles delays every subsequent event by m cycles.
- busy falls at the same edge at which done rises.

## Configuration
- SWEEP_RESULT_COUNT_EN defined: the result tag pipeline, result sampling and the onesA/onesB counters are built. DRAIN lasts RES_LAT cycles as specified.
- Not defined: onesA/onesB are tied to 0, resultA/resultB are ignored, and no pipeline is built. RUN goes straight to DONE after the last accept (DRAIN is skipped), so done is high one edge after the last accept.

## Test plan
- Reset mid-RUN: rst_n=0 for 1 edge after 37 accepts -> all outputs 0, state IDLE; a fresh start restarts at (0,0).
- Full sweep, WIDTH=4, RES_LAT=1, ready=1, resultA = (A==B), resultB = A[0]:
  - operand order (0,0),(0,1)…(0,15),(1,0)…(15,15);
  - done high after edge k+257;
  - onesA=16, onesB=128.
- Backpressure: ready toggles 1,0 every cycle -> operands stable while !ready, no pair skipped or repeated, done after edge k+512+RES_LAT.
- Wrap boundary: hold ready=0 at (3,15) for 5 cycles, then accept -> next pair (4,0); pair count is unchanged by the stall.
- Abort/start collision: abort during RUN at pair (9,2) -> valid=0 next cycle, no done pulse, operands frozen at (9,2). start+abort together in IDLE -> stays IDLE. start during RUN -> ignored.
- Macro off: same full sweep -> done high after edge k+256, onesA=onesB=0.
